result_display_fifo: RTL
========================

RESULT_DISPLAY_FIFO -- requirements
Module: result_display_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of FIFO entries; legal values are powers of two from 2 to 8.
REQ-002 Parameter SYNC_STAGES, default 2, number of flip-flops in the pop_btn synchronizer; minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_data  input  4  result nibble from the upstream processing block.
REQ-006 in_valid  input  1  in_data holds a result to be stored.
REQ-007 in_ready  output  1  the FIFO can accept a result this cycle.
REQ-008 pop_btn  input  1  raw, asynchronous push-button; a rising edge advances the display.
REQ-009 clear  input  1  synchronous clear of the error flag and FIFO contents.
REQ-010 seg  output  7  active-high segments; bit0=a through bit6=g; shows the FIFO head.
REQ-011 dp  output  1  sticky underflow error indicator.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 empty, full  output  1 each  count==0 and count==DEPTH respectively.

Function
REQ-014 The block SHALL have exactly one clock domain (clk) and asynchronous active-low reset rst_n.
REQ-015 in_ready SHALL equal !full, combinationally from registered count.
REQ-016 Push occurs on a clk edge where in_valid && in_ready: mem[wr_ptr] <= in_data, wr_ptr increments modulo DEPTH.
REQ-017 pop_btn SHALL pass through SYNC_STAGES flops, then one edge-detect flop; pop_req = sync_out && !edge_q, one cycle wide.
REQ-018 With SYNC_STAGES=2, pop_btn high before edge N and held SHALL cause pop_req high between edges N+1 and N+2 and the pointer update at edge N+2.
REQ-019 Pop occurs when pop_req && !empty: rd_ptr increments modulo DEPTH.
REQ-020 When pop_req && empty, no pointer moves, and dp SHALL set to 1 at that edge and stay set.
REQ-021 When a push and a pop occur on the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 When empty, a simultaneous push and pop_req SHALL accept the push, SHALL ignore the pop, and SHALL set dp.
REQ-023 When full, in_valid SHALL be ignored, and a pop on that edge SHALL still proceed; the push becomes possible the next cycle.
REQ-024 Pointers SHALL be $clog2(DEPTH) bits wide and wrap naturally; count SHALL be tracked separately to distinguish full from empty.
REQ-025 seg SHALL be the combinational hex decode of mem[rd_ptr] when !empty, and 7'b0000000 (blank) when empty.
REQ-026 Hex decode (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-027 clear=1 at an edge SHALL zero the pointers, count and dp, taking priority over push and pop on that edge; synchronizer flops are unaffected.
REQ-028 A hold-high pop_btn SHALL produce exactly one pop; a new pop requires pop_btn low for at least SYNC_STAGES+1 cycles, then high again.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, dp=0, and all synchronizer and edge flops to 0.
REQ-030 During reset the outputs SHALL be: empty=1, full=0, in_ready=1, seg=00.
REQ-031 FIFO storage contents SHALL be don't-care after reset, and no output SHALL depend on them while empty.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries and any in-flight pop_req.
REQ-033 Reset release SHALL be synchronous to clk, and the first push is accepted on the first edge after release.

Verification
REQ-034 After reset, push 0x3 -> count=1 and seg=4F; then pulse pop_btn -> at the 3rd edge count=0 and seg=00.
REQ-035 Push 1,2,3,4 on consecutive cycles (DEPTH=4) -> full=1, in_ready=0; a 5th in_valid of 0x5 is not stored; seg=06.
REQ-036 With full, issue a pop with in_valid held at 0x5 -> count 4→3→4, the 5th entry reads back as 5 after popping 2, 3 and 4.
REQ-037 With empty, issue a pop -> dp=1, count=0; assert clear for one cycle -> dp=0.
REQ-038 Hold pop_btn high for 20 cycles with 3 entries -> exactly one pop, count=2.
REQ-039 Assert rst_n=0 asynchronously between edges with 2 entries -> count=0 and seg=00 immediately, before the next clk edge.

Source files
------------

// File: rtl/result_display_fifo.sv
// Result FIFO with a synchronized pop push-button, 7-segment display of the head
// entry, and a sticky underflow flag shown on the decimal point.
module result_display_fifo #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   pop_btn,
    input  logic                   clear,
    output logic [6:0]             seg,
    output logic                   dp,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   edge_q;
    logic                   pop_req;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [3:0]             mem [DEPTH];
    logic [3:0]             head;
    logic                   push;
    logic                   pop;

    // Synchronizer and edge detector ignore clear; only reset touches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pop_btn};
            edge_q <= sync_out;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign pop_req  = sync_out && !edge_q;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = pop_req && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dp     <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dp     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (pop_req && empty) begin
                dp <= 1'b1;
            end
        end
    end

    // Storage has no reset; its contents are never observed while empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= in_data;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        seg = '0;
        if (!empty) begin
            case (head)
                4'h0: seg = 7'h3F;
                4'h1: seg = 7'h06;
                4'h2: seg = 7'h5B;
                4'h3: seg = 7'h4F;
                4'h4: seg = 7'h66;
                4'h5: seg = 7'h6D;
                4'h6: seg = 7'h7D;
                4'h7: seg = 7'h07;
                4'h8: seg = 7'h7F;
                4'h9: seg = 7'h6F;
                4'hA: seg = 7'h77;
                4'hB: seg = 7'h7C;
                4'hC: seg = 7'h39;
                4'hD: seg = 7'h5E;
                4'hE: seg = 7'h79;
                default: seg = 7'h71;
            endcase
        end
    end

endmodule
